// File: rtl/mxdot_pkg.sv
// mxdot_pkg: shared word types, FSM state encoding and fixed-point helpers
// for the sequential motion cross-product unit (mxdot_seq).
// Build option: define MXDOT_SAT_EN to make every shifted product and every
// sum saturate instead of wrapping.
package mxdot_pkg;

  localparam int unsigned WIDTH        = 32;
  localparam int unsigned DECIMAL_BITS = 16;

  typedef logic signed [WIDTH-1:0]   word_t;
  typedef logic signed [2*WIDTH-1:0] dword_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P0   = 3'd1,
    ST_P1   = 3'd2,
    ST_P2   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

`ifdef MXDOT_SAT_EN
  // Representable range of a WIDTH-bit word, plus its double-width image
  // used to clamp shifted products before narrowing.
  localparam word_t  SAT_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam word_t  SAT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam dword_t SAT_MAX_D = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam dword_t SAT_MIN_D = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`endif

  // Full signed product, arithmetic shift by DECIMAL_BITS, narrowed to WIDTH.
  function automatic word_t fx_mul(input word_t a, input word_t b);
    dword_t p;
    p = dword_t'(a) * dword_t'(b);
`ifdef MXDOT_SAT_EN
    p = p >>> DECIMAL_BITS;
    if (p > SAT_MAX_D) begin
      return SAT_MAX;
    end else if (p < SAT_MIN_D) begin
      return SAT_MIN;
    end
    return word_t'(p);
`else
    return word_t'(p >>> DECIMAL_BITS);
`endif
  endfunction

  function automatic word_t fx_add(input word_t a, input word_t b);
`ifdef MXDOT_SAT_EN
    logic signed [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (s[WIDTH] != s[WIDTH-1]) begin
      return s[WIDTH] ? SAT_MIN : SAT_MAX;
    end
    return s[WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  function automatic word_t fx_sub(input word_t a, input word_t b);
`ifdef MXDOT_SAT_EN
    logic signed [WIDTH:0] s;
    s = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    if (s[WIDTH] != s[WIDTH-1]) begin
      return s[WIDTH] ? SAT_MIN : SAT_MAX;
    end
    return s[WIDTH-1:0];
`else
    return a - b;
`endif
  endfunction

endpackage

// File: rtl/mxdot_cross3.sv
// mxdot_cross3: combinational fixed-point 3-vector cross product c = a x b.
// Six multipliers feed three subtractors; arithmetic honours MXDOT_SAT_EN
// through the package helpers.
module mxdot_cross3
  import mxdot_pkg::*;
(
  input  logic signed [WIDTH-1:0] i_a_x,
  input  logic signed [WIDTH-1:0] i_a_y,
  input  logic signed [WIDTH-1:0] i_a_z,
  input  logic signed [WIDTH-1:0] i_b_x,
  input  logic signed [WIDTH-1:0] i_b_y,
  input  logic signed [WIDTH-1:0] i_b_z,
  output logic signed [WIDTH-1:0] o_c_x,
  output logic signed [WIDTH-1:0] o_c_y,
  output logic signed [WIDTH-1:0] o_c_z
);

  word_t w_ay_bz, w_az_by, w_az_bx, w_ax_bz, w_ax_by, w_ay_bx;

  // Six shifted partial products.
  always_comb begin
    w_ay_bz = fx_mul(i_a_y, i_b_z);
    w_az_by = fx_mul(i_a_z, i_b_y);
    w_az_bx = fx_mul(i_a_z, i_b_x);
    w_ax_bz = fx_mul(i_a_x, i_b_z);
    w_ax_by = fx_mul(i_a_x, i_b_y);
    w_ay_bx = fx_mul(i_a_y, i_b_x);
  end

  // Pairwise differences forming each cross-product component.
  always_comb begin
    o_c_x = fx_sub(w_ay_bz, w_az_by);
    o_c_y = fx_sub(w_az_bx, w_ax_bz);
    o_c_z = fx_sub(w_ax_by, w_ay_bx);
  end

endmodule

// File: rtl/mxdot_seq.sv
// mxdot_seq: sequential motion cross product crm(v)*m for 6-element spatial
// vectors v = [w; vl], m = [ma; ml]. A single cross3 unit is reused over
// three compute states: P0 w x ma -> A, P1 w x ml -> L, P2 L += vl x ma.
// Build option: MXDOT_SAT_EN selects saturating arithmetic.
module mxdot_seq
  import mxdot_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] mxvec_in_AX,
  input  logic signed [WIDTH-1:0] mxvec_in_AY,
  input  logic signed [WIDTH-1:0] mxvec_in_AZ,
  input  logic signed [WIDTH-1:0] mxvec_in_LX,
  input  logic signed [WIDTH-1:0] mxvec_in_LY,
  input  logic signed [WIDTH-1:0] mxvec_in_LZ,
  input  logic signed [WIDTH-1:0] dotvec_in_AX,
  input  logic signed [WIDTH-1:0] dotvec_in_AY,
  input  logic signed [WIDTH-1:0] dotvec_in_AZ,
  input  logic signed [WIDTH-1:0] dotvec_in_LX,
  input  logic signed [WIDTH-1:0] dotvec_in_LY,
  input  logic signed [WIDTH-1:0] dotvec_in_LZ,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] mxdotvec_out_AX,
  output logic signed [WIDTH-1:0] mxdotvec_out_AY,
  output logic signed [WIDTH-1:0] mxdotvec_out_AZ,
  output logic signed [WIDTH-1:0] mxdotvec_out_LX,
  output logic signed [WIDTH-1:0] mxdotvec_out_LY,
  output logic signed [WIDTH-1:0] mxdotvec_out_LZ
);

  state_t r_state;
  word_t  r_w     [3];
  word_t  r_vl    [3];
  word_t  r_ma    [3];
  word_t  r_ml    [3];
  word_t  r_acc_a [3];
  word_t  r_acc_l [3];

  word_t  w_op_a  [3];
  word_t  w_op_b  [3];
  word_t  w_cx, w_cy, w_cz;

  // Steer the shared cross unit: w x ma by default, w x ml in P1, vl x ma in P2.
  always_comb begin
    w_op_a = r_w;
    w_op_b = r_ma;
    case (r_state)
      ST_P1:   w_op_b = r_ml;
      ST_P2:   w_op_a = r_vl;
      default: ;
    endcase
  end

  mxdot_cross3 u_cross (
    .i_a_x (w_op_a[0]),
    .i_a_y (w_op_a[1]),
    .i_a_z (w_op_a[2]),
    .i_b_x (w_op_b[0]),
    .i_b_y (w_op_b[1]),
    .i_b_z (w_op_b[2]),
    .o_c_x (w_cx),
    .o_c_y (w_cy),
    .o_c_z (w_cz)
  );

  // Sequencer: capture operands, run the three compute phases, hold result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      for (int unsigned i = 0; i < 3; i++) begin
        r_w[i]     <= '0;
        r_vl[i]    <= '0;
        r_ma[i]    <= '0;
        r_ml[i]    <= '0;
        r_acc_a[i] <= '0;
        r_acc_l[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_w[0]  <= mxvec_in_AX;
            r_w[1]  <= mxvec_in_AY;
            r_w[2]  <= mxvec_in_AZ;
            r_vl[0] <= mxvec_in_LX;
            r_vl[1] <= mxvec_in_LY;
            r_vl[2] <= mxvec_in_LZ;
            r_ma[0] <= dotvec_in_AX;
            r_ma[1] <= dotvec_in_AY;
            r_ma[2] <= dotvec_in_AZ;
            r_ml[0] <= dotvec_in_LX;
            r_ml[1] <= dotvec_in_LY;
            r_ml[2] <= dotvec_in_LZ;
            r_state <= ST_P0;
          end
        end
        ST_P0: begin
          r_acc_a[0] <= w_cx;
          r_acc_a[1] <= w_cy;
          r_acc_a[2] <= w_cz;
          r_state    <= ST_P1;
        end
        ST_P1: begin
          r_acc_l[0] <= w_cx;
          r_acc_l[1] <= w_cy;
          r_acc_l[2] <= w_cz;
          r_state    <= ST_P2;
        end
        ST_P2: begin
          // L = (w x ml) + (vl x ma), in this order.
          r_acc_l[0] <= fx_add(r_acc_l[0], w_cx);
          r_acc_l[1] <= fx_add(r_acc_l[1], w_cy);
          r_acc_l[2] <= fx_add(r_acc_l[2], w_cz);
          r_state    <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE) && rst_n;
  assign out_valid = (r_state == ST_DONE);

  assign mxdotvec_out_AX = r_acc_a[0];
  assign mxdotvec_out_AY = r_acc_a[1];
  assign mxdotvec_out_AZ = r_acc_a[2];
  assign mxdotvec_out_LX = r_acc_l[0];
  assign mxdotvec_out_LY = r_acc_l[1];
  assign mxdotvec_out_LZ = r_acc_l[2];

endmodule

// File: tb/tb_mxdot_seq.sv
// tb_mxdot_seq: directed and randomized checks of mxdot_seq against a
// behavioural fixed-point model of crm(v)*m.
module tb_mxdot_seq;

  typedef logic [31:0] vec6_t [6];
  typedef logic [31:0] vec3_t [3];

`ifdef MXDOT_SAT_EN
  localparam longint LIM_HI = (64'sd1 <<< 31) - 64'sd1;
  localparam longint LIM_LO = -(64'sd1 <<< 31);
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  vec6_t       r_mx;
  vec6_t       r_dv;
  logic [31:0] o_ax, o_ay, o_az, o_lx, o_ly, o_lz;
  logic [31:0] w_res [6];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  string       names [6] = '{"AX", "AY", "AZ", "LX", "LY", "LZ"};

  always #5 clk = ~clk;

  mxdot_seq dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .mxvec_in_AX     (r_mx[0]),
    .mxvec_in_AY     (r_mx[1]),
    .mxvec_in_AZ     (r_mx[2]),
    .mxvec_in_LX     (r_mx[3]),
    .mxvec_in_LY     (r_mx[4]),
    .mxvec_in_LZ     (r_mx[5]),
    .dotvec_in_AX    (r_dv[0]),
    .dotvec_in_AY    (r_dv[1]),
    .dotvec_in_AZ    (r_dv[2]),
    .dotvec_in_LX    (r_dv[3]),
    .dotvec_in_LY    (r_dv[4]),
    .dotvec_in_LZ    (r_dv[5]),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .mxdotvec_out_AX (o_ax),
    .mxdotvec_out_AY (o_ay),
    .mxdotvec_out_AZ (o_az),
    .mxdotvec_out_LX (o_lx),
    .mxdotvec_out_LY (o_ly),
    .mxdotvec_out_LZ (o_lz)
  );

  assign w_res[0] = o_ax;
  assign w_res[1] = o_ay;
  assign w_res[2] = o_az;
  assign w_res[3] = o_lx;
  assign w_res[4] = o_ly;
  assign w_res[5] = o_lz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] fit(input longint v);
    longint t;
    t = v;
`ifdef MXDOT_SAT_EN
    if (t > LIM_HI) t = LIM_HI;
    else if (t < LIM_LO) t = LIM_LO;
`endif
    return t[31:0];
  endfunction

  function automatic logic [31:0] q_mul(input logic [31:0] a, input logic [31:0] b);
    return fit((longint'($signed(a)) * longint'($signed(b))) >>> 16);
  endfunction

  function automatic logic [31:0] q_add(input logic [31:0] a, input logic [31:0] b);
    return fit(longint'($signed(a)) + longint'($signed(b)));
  endfunction

  function automatic logic [31:0] q_sub(input logic [31:0] a, input logic [31:0] b);
    return fit(longint'($signed(a)) - longint'($signed(b)));
  endfunction

  function automatic vec3_t q_cross(input vec3_t a, input vec3_t b);
    vec3_t c;
    for (int i = 0; i < 3; i++) begin
      int j;
      int k;
      j = (i + 1) % 3;
      k = (i + 2) % 3;
      c[i] = q_sub(q_mul(a[j], b[k]), q_mul(a[k], b[j]));
    end
    return c;
  endfunction

  function automatic vec6_t golden(input vec6_t mx, input vec6_t dv);
    vec3_t w, vl, ma, ml, ra, lw, lv;
    vec6_t r;
    for (int i = 0; i < 3; i++) begin
      w[i]  = mx[i];
      vl[i] = mx[i+3];
      ma[i] = dv[i];
      ml[i] = dv[i+3];
    end
    ra = q_cross(w, ma);
    lw = q_cross(w, ml);
    lv = q_cross(vl, ma);
    for (int i = 0; i < 3; i++) begin
      r[i]   = ra[i];
      r[i+3] = q_add(lw[i], lv[i]);
    end
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] v;
    if ($urandom_range(0, 3) == 0) begin
      v = 32'($urandom_range(0, 32'h0003FFFF));
      if ($urandom_range(0, 1) == 1) v = -v;
    end else begin
      v = $urandom();
    end
    return v;
  endfunction

  task automatic scramble_inputs();
    for (int i = 0; i < 6; i++) begin
      r_mx[i] = rand_word();
      r_dv[i] = rand_word();
    end
  endtask

  // Present one operand set, check latency, result, stall behaviour and the
  // output handshake. Leaves junk operands with in_valid high on return.
  task automatic run_op(input vec6_t m, input vec6_t d, input int unsigned stall, input string tag);
    vec6_t exp;
    bit    acc;
    exp = golden(m, d);
    acc = 0;
    r_mx = m;
    r_dv = d;
    in_valid = 1'b1;
    for (int n = 0; n < 8 && !acc; n++) begin
      if (in_ready) acc = 1;
      tick();
    end
    if (!acc) begin
      check({tag, "_accept_timeout"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    // Busy: operand bus and in_valid carry junk that must be ignored.
    in_valid = 1'($urandom_range(0, 1));
    out_ready = 1'($urandom_range(0, 1));
    scramble_inputs();
    tick();
    tick();
    check({tag, "_valid_early"}, {31'd0, out_valid}, 32'd0);
    tick();
    check({tag, "_valid_k3"}, {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 6; i++) check({tag, "_", names[i]}, w_res[i], exp[i]);
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int unsigned s = 0; s < stall; s++) begin
      tick();
      check({tag, "_stall_in_ready"}, {31'd0, in_ready}, 32'd0);
      check({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
    end
    if (stall > 0) begin
      for (int i = 0; i < 6; i++) check({tag, "_hold_", names[i]}, w_res[i], exp[i]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_hs_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_hs_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec6_t m, d;
    for (int i = 0; i < 6; i++) begin
      r_mx[i] = '0;
      r_dv[i] = '0;
    end

    // Reset state.
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 6; i++) check({"rst_", names[i]}, w_res[i], 32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic A: w = z-hat, ma = x-hat -> A = y-hat.
    for (int i = 0; i < 6; i++) begin m[i] = '0; d[i] = '0; end
    m[2] = 32'h0001_0000;
    d[0] = 32'h0001_0000;
    run_op(m, d, 0, "basicA");
    check("basicA_AY_const", w_res[1], 32'h0001_0000);

    // Basic L: vl = x-hat, ma = y-hat -> L = z-hat.
    for (int i = 0; i < 6; i++) begin m[i] = '0; d[i] = '0; end
    m[3] = 32'h0001_0000;
    d[1] = 32'h0001_0000;
    run_op(m, d, 0, "basicL");
    check("basicL_LZ_const", w_res[5], 32'h0001_0000);

    // Backpressure for 10 cycles with competing in_valid.
    for (int i = 0; i < 6; i++) begin m[i] = rand_word(); d[i] = rand_word(); end
    run_op(m, d, 10, "bp");

    // Overflow of a single product.
    for (int i = 0; i < 6; i++) begin m[i] = '0; d[i] = '0; end
    m[0] = 32'h7FFF_0000;
    d[1] = 32'h7FFF_0000;
    run_op(m, d, 0, "ovf");
`ifdef MXDOT_SAT_EN
    check("ovf_AZ_const", w_res[2], 32'h7FFF_FFFF);
`else
    check("ovf_AZ_const", w_res[2], 32'h0001_0000);
`endif

    // Reset while in P1 aborts the operation.
    for (int i = 0; i < 6; i++) begin m[i] = rand_word(); d[i] = rand_word(); end
    r_mx = m;
    r_dv = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 6; i++) check({"midrst_", names[i]}, w_res[i], 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_rel_out_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 6; i++) begin m[i] = rand_word(); d[i] = rand_word(); end
    run_op(m, d, 0, "postrst");

    // Random regression, back-to-back with occasional output stalls.
    for (int t = 0; t < 1000; t++) begin
      int unsigned st;
      for (int i = 0; i < 6; i++) begin m[i] = rand_word(); d[i] = rand_word(); end
      st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      run_op(m, d, st, "rnd");
    end
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
